serial_frame_tx: RTL and testbench

//   Serial frame transmitter; drives the single-wire link sampled by the serial frame receiver controller.

---
 rtl/serial_frame_tx_pkg.sv | 26 ++
 rtl/serial_frame_tx_if.sv | 28 ++
 rtl/serial_frame_tx_shift_reg.sv | 30 +++
 rtl/serial_frame_tx.sv | 186 ++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared types and line-level constants for the serial frame transmitter.
// Optional even-parity bit per payload group: define SERIAL_TX_PARITY_EN.
package serial_frame_pkg;

    localparam int HDR_W_DEF = 6;
    localparam int PAY_W_DEF = 5;

    localparam logic START_BIT  = 1'b0;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic CONT_MORE  = 1'b0;
    localparam logic CONT_END   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        HDR,
        PAY,
        PAR,
        CONT
    } tx_state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Producer-side handshake bundle: header offer and payload group stream.
// The transmitter uses the slave modport, the producer the master modport.
interface serial_frame_tx_if
    import serial_frame_pkg::*;
#(
    parameter int HDR_W = HDR_W_DEF,
    parameter int PAY_W = PAY_W_DEF
);

    logic [HDR_W-1:0] hdr;
    logic             hdr_valid;
    logic             hdr_ready;
    logic [PAY_W-1:0] pay_data;
    logic             pay_last;
    logic             pay_valid;
    logic             pay_ready;

    modport master (
        output hdr, hdr_valid, pay_data, pay_last, pay_valid,
        input  hdr_ready, pay_ready
    );

    modport slave (
        input  hdr, hdr_valid, pay_data, pay_last, pay_valid,
        output hdr_ready, pay_ready
    );

endinterface

// File: rtl/serial_frame_tx_shift_reg.sv
// Parallel-load, LSB-first shift register shared by header and payload fields.
// nxt0 is the value bit 0 will hold after the coming edge.
module serial_shift_reg #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         bit0,
    output logic         nxt0
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {1'b0, q[W-1:1]};
        end
    end

    assign bit0 = q[0];
    assign nxt0 = load ? d[0] : (shift ? q[1] : q[0]);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, header, payload groups with continuation bits.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit after each payload group.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int HDR_W = HDR_W_DEF,
    parameter int PAY_W = PAY_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    serial_frame_tx_if.slave       bus,
    output logic                   serout,
    output logic                   busy,
    output logic                   underrun
);

    localparam int SW = max_w(HDR_W, PAY_W);
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(HDR_W - 1);
    localparam logic [CW-1:0] PAY_LAST = CW'(PAY_W - 1);

    tx_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          last_q, last_d;
    logic          under_q;
    logic          serout_q, serout_d;
    logic          hdr_ready, pay_ready;
    logic          hdr_acc;
    logic          sr_load, sr_shift;
    logic [SW-1:0] sr_d;
    logic          sr_bit0, sr_nxt0;
    logic [PAY_W-1:0] grp;
    logic          grp_last;
`ifdef SERIAL_TX_PARITY_EN
    logic          par_q;
`endif

    assign hdr_acc  = bus.hdr_valid & hdr_ready;
    // A missing group is replaced by an all-zero closing group.
    assign grp      = bus.pay_valid ? bus.pay_data : '0;
    assign grp_last = bus.pay_valid ? bus.pay_last : CONT_END;
    assign last_d   = pay_ready ? grp_last : last_q;

    serial_shift_reg #(.W(SW)) u_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (sr_d),
        .bit0  (sr_bit0),
        .nxt0  (sr_nxt0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last_q   <= 1'b0;
            under_q  <= 1'b0;
            serout_q <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            last_q   <= last_d;
            serout_q <= serout_d;
            if (hdr_acc) begin
                under_q <= 1'b0;
            end else if (pay_ready & ~bus.pay_valid) begin
                under_q <= 1'b1;
            end
`ifdef SERIAL_TX_PARITY_EN
            if (pay_ready) begin
                par_q <= ^grp;
            end
`endif
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_d     = '0;
        unique case (state)
            IDLE: begin
                if (hdr_acc) begin
                    state_d = START;
                    cnt_d   = '0;
                    sr_load = 1'b1;
                    sr_d    = SW'(bus.hdr);
                end
            end
            START: begin
                if (en) begin
                    state_d = HDR;
                    cnt_d   = '0;
                end
            end
            HDR: begin
                if (en) begin
                    if (cnt == HDR_LAST) begin
                        state_d = PAY;
                        cnt_d   = '0;
                        sr_load = 1'b1;
                        sr_d    = SW'(grp);
                    end else begin
                        cnt_d    = cnt + CW'(1);
                        sr_shift = 1'b1;
                    end
                end
            end
            PAY: begin
                if (en) begin
                    if (cnt == PAY_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = CONT;
`endif
                        cnt_d = '0;
                    end else begin
                        cnt_d    = cnt + CW'(1);
                        sr_shift = 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
                if (en) begin
                    state_d = CONT;
                    cnt_d   = '0;
                end
            end
`endif
            CONT: begin
                if (en) begin
                    cnt_d = '0;
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PAY;
                        sr_load = 1'b1;
                        sr_d    = SW'(grp);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        hdr_ready = (state == IDLE) & rst_n;
        busy      = (state != IDLE);
        pay_ready = en & (((state == HDR) & (cnt == HDR_LAST)) |
                          ((state == CONT) & ~last_q));
        serout_d  = IDLE_LEVEL;
        unique case (state_d)
            IDLE:  serout_d = IDLE_LEVEL;
            START: serout_d = START_BIT;
            HDR:   serout_d = sr_nxt0;
            PAY:   serout_d = sr_nxt0;
`ifdef SERIAL_TX_PARITY_EN
            PAR:   serout_d = par_q;
`endif
            CONT:  serout_d = last_d ? CONT_END : CONT_MORE;
            default: serout_d = IDLE_LEVEL;
        endcase
    end

    assign bus.hdr_ready = hdr_ready;
    assign bus.pay_ready = pay_ready;
    assign serout        = serout_q;
    assign underrun      = under_q;

    logic unused_bit0;
    assign unused_bit0 = sr_bit0;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: frames, slow tick, underrun, async reset.
// Expected bit strings switch with SERIAL_TX_PARITY_EN.
module tb_serial_frame_tx;
    import serial_frame_pkg::*;

    logic clk;
    logic rst_n;
    logic en;
    logic serout;
    logic busy;
    logic underrun;
    int   checks;
    int   errors;

    serial_frame_tx_if #(.HDR_W(6), .PAY_W(5)) bus ();

    serial_frame_tx #(.HDR_W(6), .PAY_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bus      (bus),
        .serout   (serout),
        .busy     (busy),
        .underrun (underrun)
    );

`ifdef SERIAL_TX_PARITY_EN
    localparam string E1 = "01011011100111";
    localparam string E2 = "000000011111101000011";
    localparam string E4 = "01011010000001";
`else
    localparam string E1 = "0101101110011";
    localparam string E2 = "0000000111110100001";
    localparam string E4 = "0101101000001";
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input logic [5:0] h,
                             input logic [4:0] g0, input logic l0,
                             input logic [4:0] g1, input logic l1,
                             input logic pv, input int div,
                             input string exp, input int npulse);
        logic pr;
        int   pulses;
        @(posedge clk); #1;
        bus.hdr       = h;
        bus.hdr_valid = 1'b1;
        bus.pay_data  = g0;
        bus.pay_last  = l0;
        bus.pay_valid = pv;
        en            = (div == 1);
        @(posedge clk); #1;
        bus.hdr = ~h;
        chk("underrun_clr", underrun, 0);
        pulses = 0;
        for (int i = 0; i < exp.len(); i++) begin
            for (int k = 0; k < div; k++) begin
                en = (k == div - 1);
                bus.hdr_valid = !(i == exp.len() - 1 && k == div - 1);
                @(negedge clk);
                chk($sformatf("serout[%0d.%0d]", i, k), serout,
                    (exp[i] == 8'h31));
                chk("busy", busy, 1);
                chk("hdr_ready_busy", bus.hdr_ready, 0);
                pr = bus.pay_ready;
                if (pr) begin
                    pulses++;
                    chk("pay_ready_on_tick", en, 1);
                end
                @(posedge clk); #1;
                if (pr) begin
                    bus.pay_data = g1;
                    bus.pay_last = l1;
                end
            end
        end
        en            = 1'b0;
        bus.hdr_valid = 1'b0;
        @(negedge clk);
        chk("end_serout", serout, 1);
        chk("end_busy", busy, 0);
        chk("end_hdr_ready", bus.hdr_ready, 1);
        chk("pay_pulses", pulses, npulse);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        en            = 1'b0;
        bus.hdr       = '0;
        bus.hdr_valid = 1'b0;
        bus.pay_data  = '0;
        bus.pay_last  = 1'b0;
        bus.pay_valid = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_serout", serout, 1);
        chk("rst_busy", busy, 0);
        chk("rst_hdr_ready", bus.hdr_ready, 0);
        chk("rst_pay_ready", bus.pay_ready, 0);
        chk("rst_underrun", underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hdr_ready", bus.hdr_ready, 1);
        chk("idle_serout", serout, 1);

        run_frame(6'h2D, 5'h13, 1'b1, 5'h13, 1'b1, 1'b1, 1, E1, 1);
        run_frame(6'h00, 5'h1F, 1'b0, 5'h01, 1'b1, 1'b1, 1, E2, 2);
        run_frame(6'h2D, 5'h13, 1'b1, 5'h13, 1'b1, 1'b1, 3, E1, 1);

        run_frame(6'h2D, 5'h13, 1'b0, 5'h13, 1'b0, 1'b0, 1, E4, 1);
        chk("underrun_set", underrun, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("underrun_sticky", underrun, 1);
        run_frame(6'h2D, 5'h13, 1'b1, 5'h13, 1'b1, 1'b1, 1, E1, 1);

        @(posedge clk); #1;
        bus.hdr       = 6'h00;
        bus.hdr_valid = 1'b1;
        bus.pay_data  = 5'h13;
        bus.pay_last  = 1'b1;
        bus.pay_valid = 1'b1;
        en            = 1'b1;
        @(posedge clk); #1;
        bus.hdr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hdr3_serout", serout, 0);
        chk("hdr3_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_serout", serout, 1);
        chk("arst_busy", busy, 0);
        chk("arst_hdr_ready", bus.hdr_ready, 0);
        chk("arst_pay_ready", bus.pay_ready, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(6'h2D, 5'h13, 1'b1, 5'h13, 1'b1, 1'b1, 1, E1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
